// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the status-flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_SHL = 3'b011,
    OP_SHR = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: start loads operands and does the first step,
// done pulses for one cycle once all WIDTH partial products are accumulated.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // Folding step 1 into the load keeps total latency at WIDTH cycles.
        acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
        mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
        mplier_q <= b_i >> 1;
        cnt_q    <= CW'(1);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered 8-op ALU with valid/ready handshakes and an iterative multiplier.
// Optional ALU_SAT_EN: unsigned saturation of ADD/SUB results.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_zero,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               out_neg
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e         state_q;
  logic [2*WIDTH-1:0] result_q;
  alu_flags_t         flags_q;

  alu_op_e            op;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod, alu_res;
  alu_flags_t         alu_flags, mul_flags;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
  logic [WIDTH-1:0]   res_w;
  logic               c, v;

  assign op        = alu_op_e'(in_op);
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign shamt     = in_b[SHW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (in_a),
    .b_i     (in_b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Extended shifts leave the last bit shifted out in the extra position.
  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    shl_ext = {1'b0, in_a} << shamt;
    shr_ext = {in_a, 1'b0} >> shamt;
    res_w   = '0;
    c       = 1'b0;
    v       = 1'b0;
    case (op)
      OP_ADD: begin
        res_w = sum[WIDTH-1:0];
        c     = sum[WIDTH];
        v     = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (sum[WIDTH]) res_w = '1;
`endif
      end
      OP_SUB: begin
        res_w = diff[WIDTH-1:0];
        c     = diff[WIDTH];
        v     = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (diff[WIDTH]) res_w = '0;
`endif
      end
      OP_SHL: begin
        res_w = shl_ext[WIDTH-1:0];
        c     = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_w = shr_ext[WIDTH:1];
        c     = shr_ext[0];
      end
      OP_AND:  res_w = in_a & in_b;
      OP_OR:   res_w = in_a | in_b;
      OP_XOR:  res_w = in_a ^ in_b;
      default: res_w = '0;
    endcase
    alu_res         = {{WIDTH{1'b0}}, res_w};
    alu_flags.zero  = (res_w == '0);
    alu_flags.carry = c;
    alu_flags.ovf   = v;
    alu_flags.neg   = res_w[WIDTH-1];
    mul_flags.zero  = (mul_prod == '0);
    mul_flags.carry = 1'b0;
    mul_flags.ovf   = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags.neg   = mul_prod[2*WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q <= ST_MUL;
            end else begin
              state_q  <= ST_DONE;
              result_q <= alu_res;
              flags_q  <= alu_flags;
            end
          end else if (state_q == ST_DONE && out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q  <= ST_DONE;
            result_q <= mul_prod;
            flags_q  <= mul_flags;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_zero   = flags_q.zero;
  assign out_carry  = flags_q.carry;
  assign out_ovf    = flags_q.ovf;
  assign out_neg    = flags_q.neg;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;
  localparam int M = 1 << W;
  localparam int H = M / 2;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   in_a, in_b;
  logic [2:0]     in_op;
  logic [2*W-1:0] out_result;
  logic           out_zero, out_carry, out_ovf, out_neg;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_neg(out_neg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Returns {result[15:0], zero, carry, ovf, neg}.
  function automatic logic [2*W+3:0] model(input int op, input int a, input int b);
    int r, c, v, k, sa, sb, ss;
    logic [2*W-1:0] rr;
    logic z, n;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    k  = b % W;
    c  = 0;
    v  = 0;
    case (op)
      0: begin
        r = a + b; c = (r >= M) ? 1 : 0; r = r % M;
        ss = sa + sb; v = (ss >= H || ss < -H) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (c == 1) r = M - 1;
`endif
      end
      1: begin
        c = (a < b) ? 1 : 0; r = (a - b + M) % M;
        ss = sa - sb; v = (ss >= H || ss < -H) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (c == 1) r = 0;
`endif
      end
      2: begin r = a * b; v = (r >= M) ? 1 : 0; end
      3: begin r = (a * (1 << k)) % M; c = (k == 0) ? 0 : (a >> (W - k)) & 1; end
      4: begin r = a >> k; c = (k == 0) ? 0 : (a >> (k - 1)) & 1; end
      5: r = a & b;
      6: r = a | b;
      default: r = a ^ b;
    endcase
    rr = r[2*W-1:0];
    z  = (r == 0);
    n  = (op == 2) ? rr[2*W-1] : rr[W-1];
    return {rr, z, c[0], v[0], n};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    step(); step();
    tests++;
    if ({out_valid, out_result, out_zero, out_carry, out_ovf, out_neg} !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: valid=%b result=%h flags=%b%b%b%b in_ready=%b, required all 0 with in_ready=1",
               out_valid, out_result, out_zero, out_carry, out_ovf, out_neg, in_ready);
    end
    rst = 1'b0;
    step();
  endtask

  // One transaction from IDLE: accept, latency, result, stall hold, consume.
  task automatic run_txn(input string name, input int op, input int a, input int b, input int stall);
    logic [2*W+3:0] exp, got, first;
    int cyc;
    exp = model(op, a, b);
    in_valid = 1'b1; in_op = op[2:0]; in_a = a[W-1:0]; in_b = b[W-1:0];
    out_ready = (stall == 0);
    cyc = 0;
    while (!in_ready && cyc < 50) begin step(); cyc++; end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: in_ready never rose", name);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0; in_a = ~in_a; in_b = 8'($urandom); in_op = 3'($urandom);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 50) begin
      if (op == 2) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s busy in_ready: got %b, required 0", name, in_ready);
        end
      end
      step(); cyc++;
    end
    tests++;
    if (cyc != ((op == 2) ? W + 1 : 1)) begin
      fails++;
      $display("FAIL %s latency: got %0d, required %0d", name, cyc, (op == 2) ? W + 1 : 1);
    end
    got = {out_result, out_zero, out_carry, out_ovf, out_neg};
    first = got;
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s result op=%0d a=%h b=%h: got %h z%b c%b v%b n%b, required %h z%b c%b v%b n%b",
               name, op, a, b, got[2*W+3:4], got[3], got[2], got[1], got[0],
               exp[2*W+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
    for (int i = 0; i < stall; i++) begin
      step();
      got = {out_result, out_zero, out_carry, out_ovf, out_neg};
      tests++;
      if (got !== first || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold: got %h valid=%b in_ready=%b, required %h valid=1 in_ready=0",
                 name, got, out_valid, in_ready, first);
      end
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s consume: out_valid=%b, required 0", name, out_valid);
    end
  endtask

  task automatic test_directed();
    run_txn("add_carry", 0, 200, 100, 0);
    run_txn("sub_borrow", 1, 5, 7, 0);
    run_txn("mul_max", 2, 255, 255, 1);
    run_txn("shl", 3, 8'h81, 1, 0);
    run_txn("shr", 4, 8'h81, 3, 0);
    run_txn("shl_zero", 3, 8'hA5, 8, 0);
    run_txn("add_sovf", 0, 8'h7F, 1, 0);
    run_txn("sub_zero", 1, 8'h33, 8'h33, 0);
  endtask

  task automatic test_back_to_back();
    logic [2*W+3:0] exp, got;
    int op, a, b;
    exp = model(7, 8'hF0, 8'hFF);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'hF0; in_b = 8'hFF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {out_result, out_zero, out_carry, out_ovf, out_neg};
      tests++;
      if (got !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b xor hold: got %h valid=%b in_ready=%b, required %h valid=1 in_ready=0",
                 got, out_valid, in_ready, exp);
      end
      step();
    end
    op = 0; a = 200; b = 100;
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 8'd200; in_b = 8'd100;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b pass-through in_ready: got %b, required 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      exp = model(op, a, b);
      step();
      got = {out_result, out_zero, out_carry, out_ovf, out_neg};
      tests++;
      if (got !== exp || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b stream %0d op=%0d a=%h b=%h: got %h valid=%b, required %h",
                 i, op, a, b, got, out_valid, exp);
      end
      op = $urandom_range(0, 6);
      if (op >= 2) op++;
      a = $urandom_range(0, M - 1);
      b = $urandom_range(0, M - 1);
      in_op = op[2:0]; in_a = a[W-1:0]; in_b = b[W-1:0];
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_mul_reset();
    bit seen;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd2; in_a = 8'd12; in_b = 8'd13;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0) begin
      fails++;
      $display("FAIL mul_reset: valid=%b in_ready=%b result=%h, required 0/1/0000",
               out_valid, in_ready, out_result);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL mul_reset stale: out_valid rose after reset, required 0");
    end
    run_txn("and_after_reset", 5, 8'h3C, 8'h0F, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn("random", $urandom_range(0, 7), $urandom_range(0, M - 1),
              $urandom_range(0, M - 1), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mul_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
